// File: rtl/mdu_seq_pkg.sv
// Shared MDU definitions: ALU-decoder op encodings and sequencer states.
// Imported by the sequencer and its divide-step datapath.
package mdu_seq_pkg;

    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic is_mdu_op(input logic [7:0] op);
        return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
               (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/mdu_seq_div_step.sv
// One radix-2 restoring divide iteration on unsigned magnitudes.
// The quotient register shifts the dividend out as quotient bits shift in.
module div_step
    import mdu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < dvs always holds, so bit WIDTH of diff is a clean borrow flag
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};
    assign rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide sequencer for the EX stage.
// Stalls the pipe while busy and pulses a HI/LO write on completion.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             valid_i,
    input  logic [7:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             hilo_we_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CMAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    state_t             state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic               sgn_a;
    logic               sgn_b;
    logic               mul_signed;

    logic               start;
    logic               is_mul;
    logic               is_signed;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;

    assign start     = valid_i & ~flush & (state == IDLE) & is_mdu_op(op_i);
    assign is_mul    = (op_i == EXE_MULT_OP) || (op_i == EXE_MULTU_OP);
    assign is_signed = (op_i == EXE_MULT_OP) || (op_i == EXE_DIV_OP);
    assign mag_a     = (is_signed & a_i[WIDTH-1]) ? -a_i : a_i;
    assign mag_b     = (is_signed & b_i[WIDTH-1]) ? -b_i : b_i;

    // Sign-extending to 2*WIDTH makes the truncated product a true signed one
    assign ext_a = mul_signed ? {{WIDTH{opa[WIDTH-1]}}, opa} : {{WIDTH{1'b0}}, opa};
    assign ext_b = mul_signed ? {{WIDTH{opb[WIDTH-1]}}, opb} : {{WIDTH{1'b0}}, opb};
    assign prod  = ext_a * ext_b;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem     (rem),
        .quo     (quo),
        .dvs     (opb),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    assign q_fix = (sgn_a ^ sgn_b) ? -quo_nxt : quo_nxt;
    assign r_fix = sgn_a ? -rem_nxt : rem_nxt;

    assign stall_o   = start | (((state == MUL) || (state == DIV)) & ~flush);
    assign busy_o    = (state != IDLE);
    assign hilo_we_o = (state == DONE) & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            opa        <= '0;
            opb        <= '0;
            rem        <= '0;
            quo        <= '0;
            sgn_a      <= 1'b0;
            sgn_b      <= 1'b0;
            mul_signed <= 1'b0;
            hi_o       <= '0;
            lo_o       <= '0;
        end else if (flush) begin
            state <= IDLE;
            count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        opa        <= a_i;
                        opb        <= is_mul ? b_i : mag_b;
                        quo        <= mag_a;
                        rem        <= '0;
                        sgn_a      <= is_signed & a_i[WIDTH-1];
                        sgn_b      <= is_signed & b_i[WIDTH-1];
                        mul_signed <= is_signed;
                        count      <= '0;
                        if (is_mul) begin
                            state <= MUL;
                        end else if (b_i == '0) begin
                            state <= DONE;
                            hi_o  <= a_i;
                            lo_o  <= '1;
                        end else begin
                            state <= DIV;
                        end
                    end
                end
                MUL: begin
                    count <= count + 1'b1;
                    if (count == CW'(MUL_CYCLES - 1)) begin
                        state <= DONE;
                        hi_o  <= prod[2*WIDTH-1:WIDTH];
                        lo_o  <= prod[WIDTH-1:0];
                    end
                end
                DIV: begin
                    rem   <= rem_nxt;
                    quo   <= quo_nxt;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        hi_o  <= r_fix;
                        lo_o  <= q_fix;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
